konwersja_pipe: RTL
===================

Name: konwersja_pipe

Overview:
- Pipelined, handshaked number-format converter for the synchronous arithmetic unit.
- Converts a BITS-wide word between sign-magnitude (ZM) and two's-complement (U2), direction selected per transaction.
- Flags non-representable or degenerate inputs.
- Sits between the operand register file and the arithmetic core. Streams one conversion per clock when the downstream consumer is ready.

Parameters:
- BITS, 32, data word width (>= 2).
- ERR_CNT_BITS, 16, width of the saturating error counter (used only with the optional feature).

Ports:
- i_clk  in  1  clock, all state updates on the rising edge.
- i_rsn  in  1  reset, asynchronous, active-low.
- i_valid  in  1  input word valid.
- o_ready  out  1  converter can accept an input this cycle.
- i_mode  in  1  0 = ZM->U2, 1 = U2->ZM; sampled with i_arg_A.
- i_arg_A  in  BITS  input word.
- o_valid  out  1  o_result/o_error valid.
- i_ready  in  1  downstream accepts the output.
- o_result  out  BITS  converted word.
- o_error  out  1  conversion error for the word on o_result.
- o_err_cnt  out  ERR_CNT_BITS  accepted-error count (optional feature only).

Behaviour:
- Reset (i_rsn=0, asynchronous): both stage-valid flags are 0, o_valid=0, o_result=0, o_error=0, o_err_cnt=0. o_ready=1 from the first edge after release.
- Handshakes:
  - Input transfer occurs when i_valid & o_ready.
  - Output transfer occurs when o_valid & i_ready.
  - o_valid, o_result and o_error stay stable while o_valid=1 and i_ready=0.
- Pipeline:
  - S1 registers {i_mode, i_arg_A}.
  - S2 registers the converted result and error. S2 drives the outputs.
  - Latency: 2 cycles from input transfer to o_valid with no stall. Throughput: 1 word/cycle.
- Stall rule:
  - S2 advances when it is empty or its output transfers.
  - S1 advances into S2 when S2 advances.
  - o_ready = !S1_valid | S2 advances. Combinational from i_ready; no combinational path from i_valid.
- Input accepted on the same edge as S1 moves to S2: no bubble.
- ZM->U2 (mode 0), s = MSB, m = low BITS-1 bits:
  - s=0: result = input, error=0.
  - s=1, m!=0: result = two's-complement negation of {0,m}, error=0.
  - s=1, m=0 (negative zero): result = 0, error=1.
- U2->ZM (mode 1):
  - MSB=0: result = input, error=0.
  - MSB=1, input != {1,0...0}: result = {1, low BITS-1 bits of (~input+1)}, error=0.
  - input = {1,0...0} (most-negative value, not representable): result = {1,1...1} (saturate to the largest ZM magnitude), error=1.
- Conversion is pure combinational between S1 and S2. No state beyond the pipeline registers (plus the counter when enabled).
- Reset mid-operation: all in-flight words are discarded. No output transfer is reported for them.
- Simultaneous input and output transfer in a full pipeline: both occur and occupancy is unchanged.

Optional Feature:
- Macro: KONWERSJA_ERR_CNT_EN.
- Defined:
  - o_err_cnt exists.
  - Increments by 1 on every output transfer with o_error=1.
  - Saturates at all-ones and never wraps.
  - Reset to 0 by i_rsn.
- Not defined:
  - Port o_err_cnt and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Mode 0, i_arg_A=0x80000005, i_ready=1 -> 2 cycles later o_valid=1, o_result=0xFFFFFFFB, o_error=0.
- Mode 1, 0xFFFFFFFB -> 0x80000005, error 0.
- Boundaries:
  - Mode 0, 0x80000000 -> 0x00000000, error=1.
  - Mode 1, 0x80000000 -> 0xFFFFFFFF, error=1.
  - 0x7FFFFFFF in both modes -> 0x7FFFFFFF, error=0.
  - Mode 0, 0xFFFFFFFF -> 0x80000001.
- Backpressure:
  - Stream 4 words with i_ready=0 -> o_ready drops after 2 accepted, o_result held stable.
  - Raise i_ready -> words emerge in order with no loss or duplication.
- Back-to-back stream of 6 random words with mixed modes, i_ready=1 -> one output per cycle, each matching the reference conversion model.
- Reset:
  - Assert i_rsn=0 with both stages full -> o_valid=0 immediately; in-flight words never appear.
  - With KONWERSJA_ERR_CNT_EN and ERR_CNT_BITS=2, 5 error words accepted -> o_err_cnt=3 (saturated).

Source files
------------

// File: rtl/konwersja_pipe.sv
// konwersja_pipe
// Two-stage pipelined number-format converter with a valid/ready handshake
// on both sides. One word per clock can pass through when the consumer is
// ready. Each word carries its own direction:
//   mode 0 : sign-magnitude (ZM) -> two's complement (U2)
//   mode 1 : two's complement (U2) -> sign-magnitude (ZM)
// Inputs that cannot be represented in the target format raise o_error:
//   - ZM negative zero
//   - U2 most-negative value
//
// Ports:
//   i_clk      clock, rising edge
//   i_rsn      asynchronous active-low reset
//   i_valid    input word valid
//   o_ready    converter can take a word this cycle
//   i_mode     direction, sampled together with i_arg_A
//   i_arg_A    input word (BITS)
//   o_valid    o_result / o_error valid
//   i_ready    downstream accepts the output
//   o_result   converted word (BITS)
//   o_error    conversion error flag for o_result
//   o_err_cnt  saturating count of error words handed downstream
//              (ERR_CNT_BITS, present only with KONWERSJA_ERR_CNT_EN)
//
// Optional build macro: KONWERSJA_ERR_CNT_EN adds the o_err_cnt port and
// its counter. Without it, the port and the counter do not exist.

module konwersja_pipe #(
  parameter int BITS         = 32,
  parameter int ERR_CNT_BITS = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rsn,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_mode,
  input  logic [BITS-1:0]         i_arg_A,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [BITS-1:0]         o_result,
  output logic                    o_error
`ifdef KONWERSJA_ERR_CNT_EN
  ,
  output logic [ERR_CNT_BITS-1:0] o_err_cnt
`endif
);

  // Reject parameter values that make the conversion meaningless.
  if (BITS < 2) begin : g_badBits
    $error("konwersja_pipe: BITS must be at least 2");
  end
  if (ERR_CNT_BITS < 1) begin : g_badCnt
    $error("konwersja_pipe: ERR_CNT_BITS must be at least 1");
  end

  logic            s1Valid_q, s1Valid_d;
  logic            s1Mode_q,  s1Mode_d;
  logic [BITS-1:0] s1Data_q,  s1Data_d;
  logic            s2Valid_q, s2Valid_d;
  logic [BITS-1:0] s2Result_q, s2Result_d;
  logic            s2Error_q,  s2Error_d;

  logic            s2Advance;
  logic            inFire;
  logic            outFire;

  logic            signBit;
  logic [BITS-2:0] lowBits;
  logic            lowIsZero;
  logic [BITS-1:0] negMagnitude;
  logic [BITS-1:0] negWhole;
  logic [BITS-1:0] convResult;
  logic            convError;

  // S2 frees up when it is empty or its word leaves this cycle. S1 can then
  // always hand its word over, so a new input may enter on the same edge.
  // o_ready depends only on state and i_ready, never on i_valid.
  always_comb begin
    outFire   = s2Valid_q & i_ready;
    s2Advance = ~s2Valid_q | i_ready;
    o_ready   = ~s1Valid_q | s2Advance;
    inFire    = i_valid & o_ready;
  end

  // Format conversion on the S1 word. Both directions flag the same
  // pattern: sign bit set with all lower bits zero. ZM negative zero maps
  // to 0; U2 most-negative saturates to the largest ZM magnitude.
  always_comb begin
    signBit      = s1Data_q[BITS-1];
    lowBits      = s1Data_q[BITS-2:0];
    lowIsZero    = (lowBits == '0);
    negMagnitude = '0 - {1'b0, lowBits};
    negWhole     = '0 - s1Data_q;
    convResult   = s1Data_q;
    convError    = 1'b0;
    if (signBit) begin
      if (!s1Mode_q) begin
        if (lowIsZero) begin
          convResult = '0;
          convError  = 1'b1;
        end else begin
          convResult = negMagnitude;
        end
      end else begin
        if (lowIsZero) begin
          convResult = '1;
          convError  = 1'b1;
        end else begin
          convResult = {1'b1, negWhole[BITS-2:0]};
        end
      end
    end
  end

  // Next-state for both pipeline stages. S1 payload is only captured on an
  // actual input transfer; S2 payload only moves when S2 advances, which
  // keeps the outputs stable during a stall.
  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Mode_d   = s1Mode_q;
    s1Data_d   = s1Data_q;
    s2Valid_d  = s2Valid_q;
    s2Result_d = s2Result_q;
    s2Error_d  = s2Error_q;
    if (o_ready) begin
      s1Valid_d = i_valid;
    end
    if (inFire) begin
      s1Mode_d = i_mode;
      s1Data_d = i_arg_A;
    end
    if (s2Advance) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Result_d = convResult;
        s2Error_d  = convError;
      end
    end
  end

  // Pipeline registers; reset discards every in-flight word.
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      s1Valid_q  <= 1'b0;
      s1Mode_q   <= 1'b0;
      s1Data_q   <= '0;
      s2Valid_q  <= 1'b0;
      s2Result_q <= '0;
      s2Error_q  <= 1'b0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Mode_q   <= s1Mode_d;
      s1Data_q   <= s1Data_d;
      s2Valid_q  <= s2Valid_d;
      s2Result_q <= s2Result_d;
      s2Error_q  <= s2Error_d;
    end
  end

  assign o_valid  = s2Valid_q;
  assign o_result = s2Result_q;
  assign o_error  = s2Error_q;

`ifdef KONWERSJA_ERR_CNT_EN
  logic [ERR_CNT_BITS-1:0] errCnt_q, errCnt_d;

  // Counts error words as they are handed downstream; sticks at all-ones.
  always_comb begin
    errCnt_d = errCnt_q;
    if (outFire && s2Error_q && (errCnt_q != '1)) begin
      errCnt_d = errCnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      errCnt_q <= '0;
    end else begin
      errCnt_q <= errCnt_d;
    end
  end

  assign o_err_cnt = errCnt_q;
`else
  logic unusedOutFire;
  assign unusedOutFire = outFire;
`endif

endmodule
